// File: rtl/if_id_skid_stage_pkg.sv
// Shared CPU definitions: opcode field values, immediate-extend select codes,
// the NOP word and the IF/ID occupancy state type.
package if_id_skid_stage_pkg;

  localparam logic [15:0] NOP_INST = 16'h0800;

  localparam logic [4:0] OP_ADDIU  = 5'b01001;
  localparam logic [4:0] OP_BEQZ   = 5'b00100;
  localparam logic [4:0] OP_BNEZ   = 5'b00101;
  localparam logic [4:0] OP_ADDSP  = 5'b01100;  // shared with BTEQZ
  localparam logic [4:0] OP_LW_SP  = 5'b10010;
  localparam logic [4:0] OP_SW_SP  = 5'b11010;
  localparam logic [4:0] OP_CMPI   = 5'b01110;
  localparam logic [4:0] OP_SLTI   = 5'b01010;
  localparam logic [4:0] OP_ADDIU3 = 5'b01000;
  localparam logic [4:0] OP_B      = 5'b00010;
  localparam logic [4:0] OP_LI     = 5'b01101;
  localparam logic [4:0] OP_SLTUI  = 5'b01011;
  localparam logic [4:0] OP_LW     = 5'b10011;
  localparam logic [4:0] OP_SW     = 5'b11011;
  localparam logic [4:0] OP_SHIFT  = 5'b00110;

  localparam logic [2:0] IMM_SEL_S8    = 3'd0;
  localparam logic [2:0] IMM_SEL_S4    = 3'd1;
  localparam logic [2:0] IMM_SEL_S11   = 3'd2;
  localparam logic [2:0] IMM_SEL_NONE  = 3'd3;
  localparam logic [2:0] IMM_SEL_Z8    = 3'd4;
  localparam logic [2:0] IMM_SEL_S5    = 3'd5;
  localparam logic [2:0] IMM_SEL_SHAMT = 3'd6;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_TWO   = 2'd2
  } occ_state_e;

endpackage

// File: rtl/if_id_skid_stage_imm_sel_decode.sv
// Combinational opcode -> immediate-extend select decode.
module if_id_skid_stage_imm_sel_decode
  import if_id_skid_stage_pkg::*;
(
  input  logic [4:0] op,
  output logic [2:0] imm_sel
);

  always_comb begin
    imm_sel = IMM_SEL_NONE;
    case (op)
      OP_ADDIU, OP_BEQZ, OP_BNEZ, OP_ADDSP,
      OP_LW_SP, OP_SW_SP, OP_CMPI, OP_SLTI: imm_sel = IMM_SEL_S8;
      OP_ADDIU3:                            imm_sel = IMM_SEL_S4;
      OP_B:                                 imm_sel = IMM_SEL_S11;
      OP_LI, OP_SLTUI:                      imm_sel = IMM_SEL_Z8;
      OP_LW, OP_SW:                         imm_sel = IMM_SEL_S5;
      OP_SHIFT:                             imm_sel = IMM_SEL_SHAMT;
      default:                              imm_sel = IMM_SEL_NONE;
    endcase
  end

endmodule

// File: rtl/if_id_skid_stage.sv
// IF/ID stage with a main register and one skid entry; presents a registered
// immediate-select code decoded as each word enters the main register.
//
// Handshake: a word moves on an edge where valid and ready are both high at
// that edge (accept = f_valid & f_ready, consume = d_valid & d_ready); valid
// and payload must not change while ready is low.
module if_id_skid_stage #(
  parameter int                 DATA_W   = 16,
  parameter logic [DATA_W-1:0]  NOP_INST = if_id_skid_stage_pkg::NOP_INST
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             f_valid,
  output logic                             f_ready,
  input  logic [DATA_W-1:0]                f_pc,
  input  logic [DATA_W-1:0]                f_inst,
  input  logic                             flush,
  output logic                             d_valid,
  input  logic                             d_ready,
  output logic [DATA_W-1:0]                d_pc,
  output logic [DATA_W-1:0]                d_inst,
  output logic [2:0]                       d_imm_sel,
  output if_id_skid_stage_pkg::occ_state_e occ_state
);
  import if_id_skid_stage_pkg::*;

  occ_state_e        state_q, state_d;
  logic [DATA_W-1:0] main_pc_q, main_inst_q;
  logic [2:0]        main_sel_q;
  logic [DATA_W-1:0] skid_pc_q, skid_inst_q;

  logic              accept, consume;
  logic              load_main, main_from_skid, load_skid, clear_main;
  logic [DATA_W-1:0] mux_pc, mux_inst;
  logic [2:0]        mux_sel;

  // Ready and valid both come straight off the occupancy register.
  assign f_ready   = (state_q != OCC_TWO);
  assign d_valid   = (state_q != OCC_EMPTY);
  assign accept    = f_valid & f_ready;
  assign consume   = d_valid & d_ready;
  assign occ_state = state_q;

  always_comb begin
    state_d        = state_q;
    load_main      = 1'b0;
    main_from_skid = 1'b0;
    load_skid      = 1'b0;
    clear_main     = 1'b0;
    if (flush) begin
      state_d    = OCC_EMPTY;
      clear_main = 1'b1;
    end else begin
      case (state_q)
        OCC_EMPTY: begin
          if (accept) begin
            state_d   = OCC_ONE;
            load_main = 1'b1;
          end
        end
        OCC_ONE: begin
          if (accept && consume) begin
            load_main = 1'b1;
          end else if (accept) begin
            state_d   = OCC_TWO;
            load_skid = 1'b1;
          end else if (consume) begin
            state_d    = OCC_EMPTY;
            clear_main = 1'b1;
          end
        end
        OCC_TWO: begin
          if (consume) begin
            state_d        = OCC_ONE;
            load_main      = 1'b1;
            main_from_skid = 1'b1;
          end
        end
        default: begin
          state_d    = OCC_EMPTY;
          clear_main = 1'b1;
        end
      endcase
    end
  end

  assign mux_pc   = main_from_skid ? skid_pc_q   : f_pc;
  assign mux_inst = main_from_skid ? skid_inst_q : f_inst;

  if_id_skid_stage_imm_sel_decode u_imm_sel_decode (
    .op      (mux_inst[DATA_W-1 -: 5]),
    .imm_sel (mux_sel)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= OCC_EMPTY;
    else      state_q <= state_d;
  end

  // An empty main register shows the idle values so decode sees a clean NOP.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      main_pc_q   <= '0;
      main_inst_q <= NOP_INST;
      main_sel_q  <= IMM_SEL_NONE;
    end else if (clear_main) begin
      main_pc_q   <= '0;
      main_inst_q <= NOP_INST;
      main_sel_q  <= IMM_SEL_NONE;
    end else if (load_main) begin
      main_pc_q   <= mux_pc;
      main_inst_q <= mux_inst;
      main_sel_q  <= mux_sel;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      skid_pc_q   <= '0;
      skid_inst_q <= '0;
    end else if (load_skid) begin
      skid_pc_q   <= f_pc;
      skid_inst_q <= f_inst;
    end
  end

  assign d_pc      = main_pc_q;
  assign d_inst    = main_inst_q;
  assign d_imm_sel = main_sel_q;

endmodule
